// File: rtl/result_display_pkg.sv
// rtl/result_display_pkg.sv - shared segment constants and FSM state type for result_display
package result_display_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    localparam logic [6:0] SEG_DIGIT [0:7] = '{
        7'b1000000,
        7'b1111001,
        7'b0100100,
        7'b0110000,
        7'b0011001,
        7'b0010010,
        7'b0000010,
        7'b1111000
    };

    // Active-low digit enables: an[0] = magnitude digit, an[1] = sign digit
    localparam logic [1:0] AN_OFF  = 2'b11;
    localparam logic [1:0] AN_MAG  = 2'b10;
    localparam logic [1:0] AN_SIGN = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SHOW = 2'd2
    } state_t;

    // Sign digit pattern: minus for negative, otherwise dark
    function automatic logic [6:0] sign_pattern(input logic neg);
        return neg ? SEG_MINUS : SEG_BLANK;
    endfunction

endpackage

// File: rtl/result_display_seg7_decode.sv
// rtl/result_display_seg7_decode.sv - 3-bit digit to active-low 7-segment decoder
module seg7_decode (
    input  logic [2:0] digit,
    output logic [6:0] seg
);
    import result_display_pkg::*;

    // Table lookup; every 3-bit code has a defined glyph
    always_comb begin
        seg = SEG_DIGIT[digit];
    end

endmodule

// File: rtl/result_display.sv
// rtl/result_display.sv - result capture with minimum hold time and two-digit multiplexed display
module result_display #(
    parameter int SCAN_DIV    = 50000,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] result,
    input  logic       zeroflag,
    input  logic       res_valid,
    output logic       res_ready,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       zero_led,
    output logic       disp_valid
);
    import result_display_pkg::*;

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic                dig_sel_q, dig_sel_d;
    logic                sign_q, sign_d;
    logic [2:0]          mag_q, mag_d;
    logic                zero_led_q, zero_led_d;
    logic                disp_valid_q, disp_valid_d;
    logic                res_ready_q, res_ready_d;
    logic [6:0]          seg_q, seg_d;
    logic [1:0]          an_q, an_d;
    logic [6:0]          mag_seg;
    logic                transfer;
    logic                scan_wrap;

    // result[3] carries no information for this display
    logic unused_result_bit;
    assign unused_result_bit = result[3];

    assign transfer  = res_valid && res_ready_q;
    assign scan_wrap = (scan_cnt_q == SCAN_LAST);

    seg7_decode u_decode (
        .digit (mag_q),
        .seg   (mag_seg)
    );

    // Free-running scan counter; the digit select flips each time it wraps
    always_comb begin
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
        dig_sel_d  = dig_sel_q ^ scan_wrap;
    end

    // Capture on transfer; a zero magnitude never shows a minus sign
    always_comb begin
        sign_d       = sign_q;
        mag_d        = mag_q;
        zero_led_d   = zero_led_q;
        disp_valid_d = disp_valid_q;
        if (transfer) begin
            sign_d       = result[4] && (result[2:0] != 3'd0);
            mag_d        = result[2:0];
            zero_led_d   = zeroflag;
            disp_valid_d = 1'b1;
        end
    end

    // Handshake FSM: a captured value is held for HOLD_CYCLES before ready returns
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        res_ready_d = res_ready_q;
        case (state_q)
            IDLE, SHOW: begin
                res_ready_d = 1'b1;
                if (transfer) begin
                    state_d     = HOLD;
                    hold_cnt_d  = HOLD_LOAD;
                    res_ready_d = 1'b0;
                end
            end
            HOLD: begin
                res_ready_d = 1'b0;
                if (hold_cnt_q == '0) begin
                    state_d     = SHOW;
                    res_ready_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                hold_cnt_d  = '0;
                res_ready_d = 1'b1;
            end
        endcase
    end

    // Next display drive from the current select and captured value (one-cycle latency)
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        if (state_q != IDLE) begin
            if (dig_sel_q) begin
                an_d  = AN_SIGN;
                seg_d = sign_pattern(sign_q);
            end else begin
                an_d  = AN_MAG;
                seg_d = mag_seg;
            end
        end
    end

    // All state registers with asynchronous reset to a blank, ready display
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hold_cnt_q   <= '0;
            scan_cnt_q   <= '0;
            dig_sel_q    <= 1'b0;
            sign_q       <= 1'b0;
            mag_q        <= 3'd0;
            zero_led_q   <= 1'b0;
            disp_valid_q <= 1'b0;
            res_ready_q  <= 1'b1;
            seg_q        <= SEG_BLANK;
            an_q         <= AN_OFF;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            scan_cnt_q   <= scan_cnt_d;
            dig_sel_q    <= dig_sel_d;
            sign_q       <= sign_d;
            mag_q        <= mag_d;
            zero_led_q   <= zero_led_d;
            disp_valid_q <= disp_valid_d;
            res_ready_q  <= res_ready_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign res_ready  = res_ready_q;
    assign seg        = seg_q;
    assign an         = an_q;
    assign zero_led   = zero_led_q;
    assign disp_valid = disp_valid_q;

endmodule

// File: tb/tb_result_display.sv
// tb/tb_result_display.sv - directed self-checking bench for result_display
module tb_result_display;

    localparam int SD = 4;
    localparam int HC = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] result = 5'd0;
    logic       zeroflag = 1'b0;
    logic       res_valid = 1'b0;
    logic       res_ready;
    logic [6:0] seg;
    logic [1:0] an;
    logic       zero_led;
    logic       disp_valid;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    result_display #(.SCAN_DIV(SD), .HOLD_CYCLES(HC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .result     (result),
        .zeroflag   (zeroflag),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .seg        (seg),
        .an         (an),
        .zero_led   (zero_led),
        .disp_valid (disp_valid)
    );

    // Present a result and wait (bounded) for the transfer edge; returns 1 ns after it
    task send(input logic [4:0] r, input logic zf);
        int n;
        @(negedge clk);
        result = r;
        zeroflag = zf;
        res_valid = 1'b1;
        n = 0;
        while (res_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (res_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_timeout res_ready=%b required=1", res_ready);
        end
        @(posedge clk);
        #1;
        res_valid = 1'b0;
    endtask

    task test_reset;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (seg !== 7'b1111111) begin failures++; $display("FAIL por_seg got=%b exp=1111111", seg); end
        checks++; if (an !== 2'b11) begin failures++; $display("FAIL por_an got=%b exp=11", an); end
        checks++; if (res_ready !== 1'b1) begin failures++; $display("FAIL por_ready got=%b exp=1", res_ready); end
        checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL por_disp_valid got=%b exp=0", disp_valid); end
        checks++; if (zero_led !== 1'b0) begin failures++; $display("FAIL por_zero_led got=%b exp=0", zero_led); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (an !== 2'b11) begin failures++; $display("FAIL idle_an got=%b exp=11", an); end
    endtask

    typedef struct {
        logic [4:0] r;
        logic       zf;
        logic [6:0] d0;
        logic [6:0] d1;
    } vec_t;

    task test_capture_table;
        vec_t v [3];
        logic [1:0] prev_an;
        int run;
        bit seen_change;
        v[0] = '{5'b00101, 1'b0, 7'b0010010, 7'b1111111};
        v[1] = '{5'b10011, 1'b0, 7'b0110000, 7'b0111111};
        v[2] = '{5'b10000, 1'b1, 7'b1000000, 7'b1111111};
        for (int i = 0; i < 3; i++) begin
            send(v[i].r, v[i].zf);
            @(negedge clk);
            checks++; if (disp_valid !== 1'b1) begin failures++; $display("FAIL cap%0d_disp_valid got=%b exp=1", i, disp_valid); end
            checks++; if (res_ready !== 1'b0) begin failures++; $display("FAIL cap%0d_ready got=%b exp=0", i, res_ready); end
            checks++; if (zero_led !== v[i].zf) begin failures++; $display("FAIL cap%0d_zero_led got=%b exp=%b", i, zero_led, v[i].zf); end
            if (i == 0) begin
                checks++; if (an !== 2'b11) begin failures++; $display("FAIL cap_latency_an got=%b exp=11", an); end
            end
            @(posedge clk);
            seen_change = 1'b0;
            run = 0;
            prev_an = 2'bxx;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                checks++;
                if (an === 2'b10) begin
                    if (seg !== v[i].d0) begin failures++; $display("FAIL cap%0d_digit0 seg=%b exp=%b", i, seg, v[i].d0); end
                end else if (an === 2'b01) begin
                    if (seg !== v[i].d1) begin failures++; $display("FAIL cap%0d_digit1 seg=%b exp=%b", i, seg, v[i].d1); end
                end else begin
                    failures++; $display("FAIL cap%0d_an got=%b exp=10_or_01", i, an);
                end
                if (c > 0 && an !== prev_an) begin
                    if (seen_change) begin
                        checks++;
                        if (run != SD) begin failures++; $display("FAIL cap%0d_phase_len got=%0d exp=%0d", i, run, SD); end
                    end
                    seen_change = 1'b1;
                    run = 1;
                end else begin
                    run++;
                end
                prev_an = an;
            end
        end
    endtask

    task test_back_to_back;
        int low;
        int seen_a;
        bit found;
        @(negedge clk);
        checks++; if (res_ready !== 1'b1) begin failures++; $display("FAIL b2b_pre_ready got=%b exp=1", res_ready); end
        result = 5'b10110;
        zeroflag = 1'b0;
        res_valid = 1'b1;
        @(posedge clk);
        #1;
        result = 5'b00001;
        zeroflag = 1'b1;
        low = 0;
        seen_a = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if ((an === 2'b10 && seg === 7'b0000010) || (an === 2'b01 && seg === 7'b0111111)) seen_a++;
            if (res_ready === 1'b1) break;
            low++;
        end
        checks++; if (low != HC) begin failures++; $display("FAIL b2b_ready_low got=%0d exp=%0d", low, HC); end
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        checks++; if (res_ready !== 1'b0) begin failures++; $display("FAIL b2b_b_accept ready=%b exp=0", res_ready); end
        checks++; if (zero_led !== 1'b1) begin failures++; $display("FAIL b2b_b_zero_led got=%b exp=1", zero_led); end
        @(negedge clk);
        if ((an === 2'b10 && seg === 7'b0000010) || (an === 2'b01 && seg === 7'b0111111)) seen_a++;
        checks++; if (seen_a < HC) begin failures++; $display("FAIL b2b_a_visible got=%0d exp>=%0d", seen_a, HC); end
        found = 1'b0;
        for (int n = 0; n < 12 && !found; n++) begin
            @(negedge clk);
            if (an === 2'b10) found = 1'b1;
        end
        checks++; if (!found || seg !== 7'b1111001) begin failures++; $display("FAIL b2b_b_digit0 seg=%b exp=1111001", seg); end
    endtask

    task test_reset_mid_run;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (seg !== 7'b1111111) begin failures++; $display("FAIL mid_seg got=%b exp=1111111", seg); end
        checks++; if (an !== 2'b11) begin failures++; $display("FAIL mid_an got=%b exp=11", an); end
        checks++; if (res_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b exp=1", res_ready); end
        checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL mid_disp_valid got=%b exp=0", disp_valid); end
        checks++; if (zero_led !== 1'b0) begin failures++; $display("FAIL mid_zero_led got=%b exp=0", zero_led); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task test_reset_during_hold;
        bit found;
        send(5'b00010, 1'b0);
        checks++; if (res_ready !== 1'b0) begin failures++; $display("FAIL hold_pre_ready got=%b exp=0", res_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (an !== 2'b11) begin failures++; $display("FAIL hold_rst_an got=%b exp=11", an); end
        checks++; if (seg !== 7'b1111111) begin failures++; $display("FAIL hold_rst_seg got=%b exp=1111111", seg); end
        checks++; if (res_ready !== 1'b1) begin failures++; $display("FAIL hold_rst_ready got=%b exp=1", res_ready); end
        checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL hold_rst_disp_valid got=%b exp=0", disp_valid); end
        result = 5'b00111;
        zeroflag = 1'b1;
        res_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        checks++; if (disp_valid !== 1'b1) begin failures++; $display("FAIL post_rst_disp_valid got=%b exp=1", disp_valid); end
        checks++; if (res_ready !== 1'b0) begin failures++; $display("FAIL post_rst_ready got=%b exp=0", res_ready); end
        checks++; if (zero_led !== 1'b1) begin failures++; $display("FAIL post_rst_zero_led got=%b exp=1", zero_led); end
        found = 1'b0;
        for (int n = 0; n < 12 && !found; n++) begin
            @(negedge clk);
            if (an === 2'b10) found = 1'b1;
        end
        checks++; if (!found || seg !== 7'b1111000) begin failures++; $display("FAIL post_rst_digit0 seg=%b exp=1111000", seg); end
    endtask

    initial begin
        test_reset;
        test_capture_table;
        test_back_to_back;
        test_reset_mid_run;
        test_reset_during_hold;
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
